// File: rtl/cfg_pkg.sv
// Shared types and elaboration helpers for the block configuration loader.
// The localparams describe the default geometry; the modules derive their own from their parameters.
package cfg_pkg;

    typedef enum logic [1:0] {IDLE, FILL, COMMIT, DONE} state_e;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    localparam int DEF_MEM_SIZE   = 16;
    localparam int DEF_NUM_BLOCKS = 4;
    localparam int DEF_IN_WIDTH   = 8;
    localparam int WPB            = DEF_MEM_SIZE / DEF_IN_WIDTH;
    localparam int WORD_CNT_BITS  = max1(clog2(WPB));
    localparam int BLK_BITS       = max1(clog2(DEF_NUM_BLOCKS));

endpackage

// File: rtl/cfg_word_assembler.sv
// Packs IN_WIDTH stream words into a MEM_SIZE word, first word least significant.
// word_o already includes the slot being written, so the caller can latch it on the completing write.
module cfg_word_assembler #(
    parameter int IN_WIDTH = 8,
    parameter int WPB      = 2,
    parameter int CNT_W    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         wr_i,
    input  logic [IN_WIDTH-1:0]          data_i,
    output logic [WPB-1:0][IN_WIDTH-1:0] word_o,
    output logic                         full_o
);

    logic [WPB-1:0][IN_WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    assign full_o = wr_i && (cnt_q == CNT_W'(WPB - 1));
    assign word_o = word_d;

    for (genvar k = 0; k < WPB; k++) begin : g_slot
        assign word_d[k] = (wr_i && cnt_q == CNT_W'(k)) ? data_i : word_q[k];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (wr_i) begin
            cnt_d = full_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/block_config_loader.sv
// Streams configuration words into NUM_BLOCKS config latches, one block per COMMIT cycle.
// Every output is a flop loaded from the next-state decode, so nothing combinational leaves the block.
module block_config_loader
    import cfg_pkg::*;
#(
    parameter int MEM_SIZE   = DEF_MEM_SIZE,
    parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int IN_WIDTH   = DEF_IN_WIDTH
) (
    input  logic                  cclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [MEM_SIZE-1:0]   config_out,
    output logic [NUM_BLOCKS-1:0] cen,
    output logic                  busy,
    output logic                  done
);

    localparam int N_WPB = MEM_SIZE / IN_WIDTH;
    localparam int CNT_W = max1(clog2(N_WPB));
    localparam int BLK_W = max1(clog2(NUM_BLOCKS));

    if (MEM_SIZE % IN_WIDTH != 0) begin : g_bad_width
        $error("block_config_loader: MEM_SIZE must be a multiple of IN_WIDTH");
    end

    state_e                  state_q, state_d;
    logic [BLK_W-1:0]        blk_q, blk_d;
    logic                    in_ready_q, busy_q, done_q;
    logic [NUM_BLOCKS-1:0]   cen_q;
    logic [MEM_SIZE-1:0]     config_q, asm_word;
    logic                    wr, asm_full, asm_clr;

    // in_ready_q mirrors "state is FILL", so it doubles as the transfer qualifier
    assign wr      = in_valid && in_ready_q && !abort;
    assign asm_clr = abort || !in_ready_q;

    cfg_word_assembler #(
        .IN_WIDTH (IN_WIDTH),
        .WPB      (N_WPB),
        .CNT_W    (CNT_W)
    ) u_asm (
        .clk    (cclk),
        .rst_n  (rst_n),
        .clr_i  (asm_clr),
        .wr_i   (wr),
        .data_i (in_data),
        .word_o (asm_word),
        .full_o (asm_full)
    );

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        if (abort) begin
            state_d = IDLE;
            blk_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FILL;
                        blk_d   = '0;
                    end
                end
                FILL: begin
                    if (asm_full) state_d = COMMIT;
                end
                COMMIT: begin
                    if (blk_q == BLK_W'(NUM_BLOCKS - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                        blk_d   = blk_q + BLK_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            blk_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cen_q      <= '0;
            config_q   <= '0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            in_ready_q <= (state_d == FILL);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
            cen_q      <= (state_d == COMMIT) ? (NUM_BLOCKS'(1) << blk_d) : '0;
            if (state_d == COMMIT) config_q <= asm_word;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cen        = cen_q;
    assign config_out = config_q;

endmodule

// File: tb/tb_block_config_loader.sv
// Directed and random stimulus for block_config_loader against a transaction-level model.
module tb_block_config_loader;

    localparam int MS = 16;
    localparam int NB = 4;
    localparam int IW = 8;
    localparam int WP = MS / IW;

    logic          cclk = 1'b0;
    logic          rst_n, start, abort, in_valid;
    logic [IW-1:0] in_data;
    logic          in_ready, busy, done;
    logic [MS-1:0] config_out;
    logic [NB-1:0] cen;

    logic          start2, in_valid2;
    logic [15:0]   in_data2;
    logic          in_ready2, busy2, done2;
    logic [15:0]   config_out2;
    logic [0:0]    cen2;

    always #5 cclk = ~cclk;

    block_config_loader #(.MEM_SIZE(MS), .NUM_BLOCKS(NB), .IN_WIDTH(IW)) dut (
        .cclk(cclk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .config_out(config_out), .cen(cen), .busy(busy), .done(done)
    );

    block_config_loader #(.MEM_SIZE(16), .NUM_BLOCKS(1), .IN_WIDTH(16)) dut2 (
        .cclk(cclk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .config_out(config_out2), .cen(cen2), .busy(busy2), .done(done2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: ready = accepting words, cen_blk >= 0 = block being committed now
    bit          m_ready, m_busy, m_done, m_acc;
    int          m_blk, m_cen_blk;
    logic [MS-1:0] m_cfg;
    logic [IW-1:0] m_q[$];

    int            n_cen, n_busy;
    logic [NB-1:0] cen_seen;
    logic [MS-1:0] cfg_log[$];

    function automatic void model_step();
        m_acc = 1'b0;
        if (!rst_n) begin
            m_ready = 0; m_busy = 0; m_done = 0; m_cen_blk = -1; m_blk = 0; m_cfg = '0;
            m_q.delete();
        end else if (abort) begin
            m_ready = 0; m_busy = 0; m_done = 0; m_cen_blk = -1; m_blk = 0;
            m_q.delete();
        end else if (m_ready) begin
            if (in_valid) begin
                m_acc = 1'b1;
                m_q.push_back(in_data);
                if (m_q.size() == WP) begin
                    m_cfg = '0;
                    foreach (m_q[k]) m_cfg |= MS'(m_q[k]) << (IW * k);
                    m_q.delete();
                    m_ready   = 0;
                    m_cen_blk = m_blk;
                end
            end
        end else if (m_cen_blk >= 0) begin
            if (m_cen_blk == NB - 1) m_done = 1;
            else begin
                m_blk++;
                m_ready = 1;
            end
            m_cen_blk = -1;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (start) begin
            m_busy = 1; m_ready = 1; m_blk = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [31:0] exp_cen;
        @(posedge cclk);
        model_step();
        #1;
        exp_cen = (m_cen_blk >= 0) ? (32'd1 << m_cen_blk) : 32'd0;
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("cen", 32'(cen), exp_cen);
        chk("config_out", 32'(config_out), 32'(m_cfg));
        if (cen != '0) begin
            n_cen++;
            cen_seen |= cen;
            cfg_log.push_back(config_out);
        end
        if (busy) n_busy++;
    endtask

    task automatic feed(input logic [IW-1:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        do begin
            cyc();
            n++;
        end while (!m_acc && n < 20);
        chk("feed_accept", 32'(m_acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        logic [IW-1:0] words[8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        logic [MS-1:0] exp_cfg[4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

        m_ready = 0; m_busy = 0; m_done = 0; m_cen_blk = -1; m_blk = 0; m_cfg = '0;
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        start2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;

        // reset held with start and in_valid high
        repeat (3) begin
            cyc();
            chk("reset_cen", 32'(cen), 32'd0);
            chk("reset_cfg", 32'(config_out), 32'd0);
        end
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        cyc();

        // full load, continuous valid
        n_cen = 0; n_busy = 0; cen_seen = '0; cfg_log.delete();
        pulse_start();
        foreach (words[i]) feed(words[i]);
        repeat (3) cyc();
        chk("full_cen_count", 32'(n_cen), 32'd4);
        chk("full_busy_cycles", 32'(n_busy), 32'd13);
        chk("full_cen_mask", 32'(cen_seen), 32'hF);
        chk("full_log_size", 32'(cfg_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < cfg_log.size(); i++)
            chk($sformatf("full_cfg%0d", i), 32'(cfg_log[i]), 32'(exp_cfg[i]));

        // back-pressure gaps on block 0, then abort inside block 2
        n_cen = 0; cen_seen = '0;
        pulse_start();
        in_data = 8'h34; in_valid = 1'b1; cyc();
        in_data = 8'hFF; in_valid = 1'b0; cyc();
        in_data = 8'hEE; cyc();
        in_data = 8'h12; in_valid = 1'b1; cyc();
        in_valid = 1'b0; cyc();
        chk("bp_cen_count", 32'(n_cen), 32'd1);
        chk("bp_cfg", 32'(config_out), 32'h1234);
        feed(8'h78); feed(8'h56);
        feed(8'hBC);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        cyc();
        chk("abort_cfg", 32'(config_out), 32'h5678);
        chk("abort_no_cen2", 32'(cen_seen[2]), 32'd0);
        cen_seen = '0;
        pulse_start();
        feed(8'h11); feed(8'h22); cyc();
        chk("restart_blk0", 32'(cen_seen), 32'h1);

        // start pulsed while filling, abort and start together
        abort = 1'b1; cyc(); abort = 1'b0;
        cen_seen = '0;
        pulse_start();
        feed(8'h33);
        start = 1'b1; cyc(); start = 1'b0;
        feed(8'h44); cyc();
        chk("start_in_fill", 32'(cen_seen), 32'h1);
        chk("start_in_fill_cfg", 32'(config_out), 32'h4433);
        abort = 1'b1; start = 1'b1; cyc(); abort = 1'b0; start = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            start    = ($urandom_range(0, 7) == 0);
            abort    = ($urandom_range(0, 59) == 0);
            in_valid = $urandom_range(0, 1);
            in_data  = IW'($urandom);
            cyc();
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        abort = 1'b1; cyc(); abort = 1'b0;

        // single-word, single-block configuration
        start2 = 1'b1; cyc(); start2 = 1'b0;
        chk("w16_ready", 32'(in_ready2), 32'd1);
        in_data2 = 16'hA5A5; in_valid2 = 1'b1; cyc(); in_valid2 = 1'b0;
        chk("w16_cen", 32'(cen2), 32'd1);
        chk("w16_cfg", 32'(config_out2), 32'hA5A5);
        chk("w16_done_early", 32'(done2), 32'd0);
        cyc();
        chk("w16_cen_off", 32'(cen2), 32'd0);
        chk("w16_done", 32'(done2), 32'd1);
        cyc();
        chk("w16_idle", 32'(busy2), 32'd0);
        chk("w16_done_off", 32'(done2), 32'd0);
        chk("w16_cfg_hold", 32'(config_out2), 32'hA5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
